// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB-SPI register bank: register indices,
// bit positions inside CTRL / STATUS / ERR, and the APB slave FSM states.
package apb_spi_pkg;

    // Register indices (PADDR value)
    localparam int unsigned REG_TXDATA = 0;
    localparam int unsigned REG_RXDATA = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_CTRL   = 3;
    localparam int unsigned REG_COUNT  = 4;
    localparam int unsigned REG_ERR    = 5;

    // CTRL bit positions
    localparam int unsigned CTRL_W       = 4;
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE_RXNE = 1;
    localparam int unsigned CTRL_IE_TXE  = 2;
    localparam int unsigned CTRL_IE_ERR  = 3;

    // STATUS bit positions
    localparam int unsigned STATUS_RX_EMPTY = 0;
    localparam int unsigned STATUS_RX_FULL  = 1;
    localparam int unsigned STATUS_TX_EMPTY = 2;
    localparam int unsigned STATUS_TX_FULL  = 3;

    // ERR bit positions
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned ERR_TX_OVF = 0;
    localparam int unsigned ERR_RX_UDF = 1;
    localparam int unsigned ERR_RX_OVR = 2;

    // APB slave FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ACC1  = 2'd2,
        ACC2  = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_spi_regs_if.sv
// APB bus bundle between the APB master and the APB-SPI register bank.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0),
// followed by access cycles (PSEL=1, PENABLE=1) during which the master
// holds PADDR/PWRITE/PWDATA stable. The transfer completes on the one
// clock edge where PREADY=1; PRDATA and PSLVERR are only meaningful in
// that cycle. PREADY is never asserted outside an access.
interface apb_spi_regs_if #(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned DWIDTH = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_spi_regs.sv
// APB slave register bank in front of the SPI TX/RX FIFOs and SPI master.
// Each transfer runs SETUP -> ACC1 -> ACC2: the access is decoded on entry
// to ACC1 (FIFO strobe high for the whole of ACC1), registers update at the
// end of ACC1, and PREADY/PRDATA/PSLVERR are presented in ACC2.
module apb_spi_regs
    import apb_spi_pkg::*;
#(
    parameter int unsigned AWIDTH     = 4,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned FIFO_DEPTH = 5,
    parameter int unsigned N          = $clog2(FIFO_DEPTH + 1),
    parameter int unsigned REGN       = 6
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_spi_regs_if.slave     apb,
    output logic              TX_PUSH,
    output logic [DWIDTH-1:0] TX_WDATA,
    input  logic              TX_FULL,
    input  logic              TX_EMPTY,
    input  logic [N-1:0]      TX_CNT,
    output logic              RX_POP,
    input  logic [DWIDTH-1:0] RX_RDATA,
    input  logic              RX_FULL,
    input  logic              RX_EMPTY,
    input  logic [N-1:0]      RX_CNT,
    input  logic              RX_DV,
    output logic              SPI_EN,
    output logic              IRQ,
    output apb_state_t        dbg_state
);

    apb_state_t        state;
    logic [DWIDTH-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic              push_q;
    logic              pop_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [ERR_W-1:0]  err_q;
    logic              irq_q;

    // Access decoded at SETUP->ACC1, consumed during ACC1
    logic [AWIDTH-1:0] acc_idx;
    logic              acc_write;
    logic              acc_slverr;
    logic              acc_ovf;
    logic              acc_udf;
    logic              acc_ctrl_we;
    logic              acc_err_we;
    logic [3:0]        acc_wdata;

    // Live decode of the bus during the SETUP state
    logic              dec_push;
    logic              dec_pop;
    logic              dec_slverr;
    logic              dec_ovf;
    logic              dec_udf;
    logic              dec_ctrl_we;
    logic              dec_err_we;

    logic [DWIDTH-1:0] rd_mux;
    logic [ERR_W-1:0]  err_set;
    logic [ERR_W-1:0]  err_clr;
    logic [ERR_W-1:0]  err_next;

    // Decode the pending access against the current FIFO flags
    always_comb begin
        dec_push    = 1'b0;
        dec_pop     = 1'b0;
        dec_slverr  = 1'b0;
        dec_ovf     = 1'b0;
        dec_udf     = 1'b0;
        dec_ctrl_we = 1'b0;
        dec_err_we  = 1'b0;
        case (32'(apb.PADDR))
            REG_TXDATA: begin
                if (!apb.PWRITE)  dec_slverr = 1'b1;
                else if (TX_FULL) begin
                    dec_slverr = 1'b1;
                    dec_ovf    = 1'b1;
                end else          dec_push   = 1'b1;
            end
            REG_RXDATA: begin
                if (apb.PWRITE)    dec_slverr = 1'b1;
                else if (RX_EMPTY) begin
                    dec_slverr = 1'b1;
                    dec_udf    = 1'b1;
                end else           dec_pop    = 1'b1;
            end
            REG_STATUS: dec_slverr  = apb.PWRITE;
            REG_COUNT:  dec_slverr  = apb.PWRITE;
            REG_CTRL:   dec_ctrl_we = apb.PWRITE;
            REG_ERR:    dec_err_we  = apb.PWRITE;
            default:    dec_slverr  = 1'b1;
        endcase
        if (32'(apb.PADDR) >= REGN) dec_slverr = 1'b1;
    end

    // Read data for the access in ACC1; RX_RDATA is still the pre-pop head
    always_comb begin
        rd_mux = '0;
        if (!acc_write && !acc_slverr) begin
            case (32'(acc_idx))
                REG_RXDATA: rd_mux = RX_RDATA;
                REG_STATUS: begin
                    rd_mux[STATUS_RX_EMPTY] = RX_EMPTY;
                    rd_mux[STATUS_RX_FULL]  = RX_FULL;
                    rd_mux[STATUS_TX_EMPTY] = TX_EMPTY;
                    rd_mux[STATUS_TX_FULL]  = TX_FULL;
                end
                REG_CTRL:   rd_mux[CTRL_W-1:0] = ctrl_q;
                REG_COUNT: begin
                    rd_mux[N-1:0] = TX_CNT;
                    rd_mux[N+3:4] = RX_CNT;
                end
                REG_ERR:    rd_mux[ERR_W-1:0] = err_q;
                default:    rd_mux = '0;
            endcase
        end
    end

    // Error sticky bits: new events take priority over W1C
    always_comb begin
        err_set = '0;
        err_clr = '0;
        err_set[ERR_RX_OVR] = RX_DV & RX_FULL;
        if (state == ACC1) begin
            err_set[ERR_TX_OVF] = acc_ovf;
            err_set[ERR_RX_UDF] = acc_udf;
            if (acc_err_we) err_clr = acc_wdata[ERR_W-1:0];
        end
        err_next = (err_q & ~err_clr) | err_set;
    end

    // APB FSM, register bank and all registered outputs
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            wdata_q     <= '0;
            ctrl_q      <= '0;
            err_q       <= '0;
            irq_q       <= 1'b0;
            acc_idx     <= '0;
            acc_write   <= 1'b0;
            acc_slverr  <= 1'b0;
            acc_ovf     <= 1'b0;
            acc_udf     <= 1'b0;
            acc_ctrl_we <= 1'b0;
            acc_err_we  <= 1'b0;
            acc_wdata   <= '0;
        end else begin
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_q     <= err_next;
            irq_q     <= ctrl_q[CTRL_EN] &
                         ((ctrl_q[CTRL_IE_RXNE] & ~RX_EMPTY) |
                          (ctrl_q[CTRL_IE_TXE]  &  TX_EMPTY) |
                          (ctrl_q[CTRL_IE_ERR]  & |err_q));
            case (state)
                IDLE: begin
                    if (apb.PSEL && !apb.PENABLE) state <= SETUP;
                end
                SETUP: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else if (apb.PENABLE) begin
                        state       <= ACC1;
                        push_q      <= dec_push;
                        pop_q       <= dec_pop;
                        if (dec_push) wdata_q <= apb.PWDATA;
                        acc_idx     <= apb.PADDR;
                        acc_write   <= apb.PWRITE;
                        acc_slverr  <= dec_slverr;
                        acc_ovf     <= dec_ovf;
                        acc_udf     <= dec_udf;
                        acc_ctrl_we <= dec_ctrl_we;
                        acc_err_we  <= dec_err_we;
                        acc_wdata   <= apb.PWDATA[3:0];
                    end
                end
                ACC1: begin
                    // The strobe has already gone out, so the register side
                    // effects commit even if the master abandons the access.
                    if (acc_ctrl_we) ctrl_q <= acc_wdata[CTRL_W-1:0];
                    if (apb.PSEL) begin
                        state     <= ACC2;
                        pready_q  <= 1'b1;
                        pslverr_q <= acc_slverr;
                        prdata_q  <= rd_mux;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC2: begin
                    state <= (apb.PSEL && !apb.PENABLE) ? SETUP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are qualified by PRESETn so a reset landing mid-ACC1
    // drops the pulse immediately instead of one edge later.
    assign TX_PUSH     = push_q & PRESETn;
    assign RX_POP      = pop_q & PRESETn;
    assign TX_WDATA    = wdata_q;
    assign SPI_EN      = ctrl_q[CTRL_EN];
    assign IRQ         = irq_q;
    assign dbg_state   = state;
    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_spi_regs.sv
// Bench for apb_spi_regs: APB driver tasks, a negedge monitor that pops an
// expected-response queue on every PREADY, and strobe counters.
module tb_apb_spi_regs;
    import apb_spi_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NW = 3;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          TX_PUSH;
    logic [DW-1:0] TX_WDATA;
    logic          TX_FULL, TX_EMPTY;
    logic [NW-1:0] TX_CNT;
    logic          RX_POP;
    logic [DW-1:0] RX_RDATA;
    logic          RX_FULL, RX_EMPTY;
    logic [NW-1:0] RX_CNT;
    logic          RX_DV;
    logic          SPI_EN, IRQ;
    apb_state_t    dbg_state;

    apb_spi_regs_if #(.AWIDTH(AW), .DWIDTH(DW)) apb ();

    apb_spi_regs dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .apb      (apb),
        .TX_PUSH  (TX_PUSH),
        .TX_WDATA (TX_WDATA),
        .TX_FULL  (TX_FULL),
        .TX_EMPTY (TX_EMPTY),
        .TX_CNT   (TX_CNT),
        .RX_POP   (RX_POP),
        .RX_RDATA (RX_RDATA),
        .RX_FULL  (RX_FULL),
        .RX_EMPTY (RX_EMPTY),
        .RX_CNT   (RX_CNT),
        .RX_DV    (RX_DV),
        .SPI_EN   (SPI_EN),
        .IRQ      (IRQ),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int err_cnt = 0;
    int chk_cnt = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic [DW-1:0] last_wdata = '0;
    logic          irq_at_ready = 1'b0;
    logic [9:0]    exp_q[$];   // {check_prdata, pslverr, prdata}
    string         tag_q[$];
    logic [9:0]    mon_e;
    string         mon_tag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: strobes and completed transfers
    always @(negedge PCLK) begin
        if (TX_PUSH) begin
            push_cnt++;
            last_wdata = TX_WDATA;
            check("push_in_acc1", 32'(dbg_state), 32'(ACC1));
        end
        if (RX_POP) begin
            pop_cnt++;
            check("pop_in_acc1", 32'(dbg_state), 32'(ACC1));
        end
        if (apb.PREADY) begin
            irq_at_ready = IRQ;
            if (exp_q.size() == 0) begin
                check("unexpected_pready", 32'd1, 32'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check({mon_tag, "_pslverr"}, 32'(apb.PSLVERR), 32'(mon_e[8]));
                if (mon_e[9]) check({mon_tag, "_prdata"}, 32'(apb.PRDATA), 32'(mon_e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic exp_err,
                            input logic [DW-1:0] exp_data);
        int setup_cyc;
        bit seen;
        exp_q.push_back({~wr, exp_err, exp_data});
        tag_q.push_back(tag);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        @(posedge PCLK); #1;
        setup_cyc   = cyc;
        apb.PENABLE = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge PCLK);
            if (apb.PREADY) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(cyc - setup_cyc), 32'd2);
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_back());
            void'(tag_q.pop_back());
        end
        @(posedge PCLK); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_prdata"},   32'(apb.PRDATA),  32'd0);
        check({pfx, "_pready"},   32'(apb.PREADY),  32'd0);
        check({pfx, "_pslverr"},  32'(apb.PSLVERR), 32'd0);
        check({pfx, "_tx_push"},  32'(TX_PUSH),     32'd0);
        check({pfx, "_rx_pop"},   32'(RX_POP),      32'd0);
        check({pfx, "_tx_wdata"}, 32'(TX_WDATA),    32'd0);
        check({pfx, "_spi_en"},   32'(SPI_EN),      32'd0);
        check({pfx, "_irq"},      32'(IRQ),         32'd0);
        check({pfx, "_state"},    32'(dbg_state),   32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    int p0;
    logic [3:0]    rflags;
    logic [NW-1:0] rtx, rrx;

    initial begin
        PRESETn     = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        TX_FULL = 1'b0; TX_EMPTY = 1'b1; TX_CNT = '0;
        RX_FULL = 1'b0; RX_EMPTY = 1'b1; RX_CNT = '0;
        RX_RDATA = '0;  RX_DV = 1'b0;
        idle(3);
        @(negedge PCLK);
        check_reset("reset");
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        idle(1);

        // Reset register contents
        apb_xfer("rd_ctrl_rst",   1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
        apb_xfer("rd_err_rst",    1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
        apb_xfer("rd_status_rst", 1'b0, 4'd2, 8'h00, 1'b0, 8'h05);

        // TXDATA push and overflow
        p0 = push_cnt;
        apb_xfer("wr_tx", 1'b1, 4'd0, 8'hA5, 1'b0, 8'h00);
        check("tx_push_once", 32'(push_cnt - p0), 32'd1);
        check("tx_wdata", 32'(last_wdata), 32'hA5);
        TX_FULL = 1'b1;
        p0 = push_cnt;
        apb_xfer("wr_tx_full", 1'b1, 4'd0, 8'h5A, 1'b1, 8'h00);
        check("tx_full_no_push", 32'(push_cnt - p0), 32'd0);
        TX_FULL = 1'b0;
        apb_xfer("rd_err_ovf",  1'b0, 4'd5, 8'h00, 1'b0, 8'h01);
        apb_xfer("w1c_ovf",     1'b1, 4'd5, 8'h01, 1'b0, 8'h00);
        apb_xfer("rd_err_clr0", 1'b0, 4'd5, 8'h00, 1'b0, 8'h00);
        apb_xfer("rd_txdata",   1'b0, 4'd0, 8'h00, 1'b1, 8'h00);

        // RXDATA pop and underflow
        RX_RDATA = 8'h3C; RX_EMPTY = 1'b0;
        p0 = pop_cnt;
        apb_xfer("rd_rx", 1'b0, 4'd1, 8'h00, 1'b0, 8'h3C);
        check("rx_pop_once", 32'(pop_cnt - p0), 32'd1);
        RX_EMPTY = 1'b1;
        p0 = pop_cnt;
        apb_xfer("rd_rx_empty", 1'b0, 4'd1, 8'h00, 1'b1, 8'h00);
        check("rx_empty_no_pop", 32'(pop_cnt - p0), 32'd0);
        apb_xfer("rd_err_udf",  1'b0, 4'd5, 8'h00, 1'b0, 8'h02);
        apb_xfer("w1c_udf",     1'b1, 4'd5, 8'h02, 1'b0, 8'h00);
        apb_xfer("wr_rxdata",   1'b1, 4'd1, 8'hFF, 1'b1, 8'h00);
        apb_xfer("wr_status",   1'b1, 4'd2, 8'hFF, 1'b1, 8'h00);
        apb_xfer("wr_count",    1'b1, 4'd4, 8'hFF, 1'b1, 8'h00);
        apb_xfer("rd_err_clr1", 1'b0, 4'd5, 8'h00, 1'b0, 8'h00);

        // Random STATUS / COUNT snapshots
        for (int k = 0; k < 4; k++) begin
            rflags = 4'($urandom_range(0, 15));
            rtx    = NW'($urandom_range(0, 5));
            rrx    = NW'($urandom_range(0, 5));
            {TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY} = rflags;
            TX_CNT = rtx;
            RX_CNT = rrx;
            apb_xfer("rd_status_rnd", 1'b0, 4'd2, 8'h00, 1'b0, {4'b0, rflags});
            apb_xfer("rd_count_rnd",  1'b0, 4'd4, 8'h00, 1'b0, {1'b0, rrx, 1'b0, rtx});
        end
        TX_FULL = 1'b0; TX_EMPTY = 1'b1; RX_FULL = 1'b0; RX_EMPTY = 1'b1;
        TX_CNT = '0; RX_CNT = '0;

        // CTRL and IRQ
        RX_EMPTY = 1'b0;
        apb_xfer("wr_ctrl3", 1'b1, 4'd3, 8'h03, 1'b0, 8'h00);
        check("spi_en_set", 32'(SPI_EN), 32'd1);
        check("irq_not_yet", 32'(irq_at_ready), 32'd0);
        check("irq_set", 32'(IRQ), 32'd1);
        apb_xfer("wr_ctrl1", 1'b1, 4'd3, 8'hF1, 1'b0, 8'h00);
        check("irq_fall", 32'(IRQ), 32'd0);
        check("spi_en_hold", 32'(SPI_EN), 32'd1);
        apb_xfer("rd_ctrl1", 1'b0, 4'd3, 8'h00, 1'b0, 8'h01);
        RX_EMPTY = 1'b1;

        // Overrun: set beats W1C in the same cycle
        RX_DV = 1'b1; RX_FULL = 1'b1;
        idle(1);
        RX_DV = 1'b0; RX_FULL = 1'b0;
        apb_xfer("rd_err_ovr", 1'b0, 4'd5, 8'h00, 1'b0, 8'h04);
        RX_DV = 1'b1; RX_FULL = 1'b1;
        apb_xfer("w1c_ovr_race", 1'b1, 4'd5, 8'h04, 1'b0, 8'h00);
        RX_DV = 1'b0; RX_FULL = 1'b0;
        apb_xfer("rd_err_ovr_kept", 1'b0, 4'd5, 8'h00, 1'b0, 8'h04);
        apb_xfer("w1c_ovr",         1'b1, 4'd5, 8'h04, 1'b0, 8'h00);
        apb_xfer("rd_err_ovr_clr",  1'b0, 4'd5, 8'h00, 1'b0, 8'h00);

        // Back-to-back pushes and unmapped indices
        p0 = push_cnt;
        apb_xfer("b2b_tx1", 1'b1, 4'd0, 8'h11, 1'b0, 8'h00);
        apb_xfer("b2b_tx2", 1'b1, 4'd0, 8'h22, 1'b0, 8'h00);
        apb_xfer("rd_idx7", 1'b0, 4'd7, 8'h00, 1'b1, 8'h00);
        check("b2b_push_cnt", 32'(push_cnt - p0), 32'd2);
        check("b2b_wdata", 32'(last_wdata), 32'h22);
        apb_xfer("wr_idx15",    1'b1, 4'd15, 8'hAA, 1'b1, 8'h00);
        apb_xfer("rd_ctrl_pre", 1'b0, 4'd3,  8'h00, 1'b0, 8'h01);

        // Reset landing in ACC1 of a TXDATA write
        p0 = push_cnt;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 4'd0; apb.PWDATA = 8'h77;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("rst_state_acc1", 32'(dbg_state), 32'(ACC1));
        PRESETn = 1'b0;
        @(negedge PCLK);
        check("rst_no_push_acc1", 32'(TX_PUSH), 32'd0);
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        check_reset("rst_mid");
        check("rst_push_cnt", 32'(push_cnt - p0), 32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        idle(1);
        apb_xfer("rd_ctrl_post", 1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
        apb_xfer("rd_err_post",  1'b0, 4'd5, 8'h00, 1'b0, 8'h00);

        idle(2);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
